// File: rtl/amdc_spi_adc_emulator_pkg.sv
// rtl/amdc_spi_adc_emulator_pkg.sv - shared constants and state encoding for the eddy-current ADC emulator
package amdc_spi_adc_emulator_pkg;

  localparam int ADC_DATA_W    = 18;
  localparam int TCONV_DEFAULT = 40;
  localparam int SYNC_DEFAULT  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_READ = 2'd2,
    ST_DONE = 2'd3
  } adc_state_e;

endpackage

// File: rtl/amdc_spi_adc_emulator_sync_edge.sv
// rtl/amdc_spi_adc_emulator_sync_edge.sv - multi-flop synchronizer with registered rise/fall pulses
import amdc_spi_adc_emulator_pkg::*;

module amdc_spi_adc_emulator_sync_edge #(
  parameter int STAGES = SYNC_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic level_o,
  output logic level_vld_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES:0]   vld_q;
  logic              prev_q;
  logic              rise_q;
  logic              fall_q;

  // vld_q tracks which flops hold a real pin sample rather than a reset value,
  // so a pin that is already high at reset release never produces a fake rise.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      vld_q  <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      vld_q  <= {vld_q[STAGES-1:0], 1'b1};
      prev_q <= sync_q[STAGES-1];
      rise_q <= vld_q[STAGES] & sync_q[STAGES-1] & ~prev_q;
      fall_q <= vld_q[STAGES] & ~sync_q[STAGES-1] & prev_q;
    end
  end

  assign level_o     = sync_q[STAGES-1];
  assign level_vld_o = vld_q[STAGES-1];
  assign rise_o      = rise_q;
  assign fall_o      = fall_q;

endmodule

// File: rtl/amdc_spi_adc_emulator.sv
// rtl/amdc_spi_adc_emulator.sv - SPI responder emulating the dual 18-bit CNV-triggered eddy-current ADCs
import amdc_spi_adc_emulator_pkg::*;

module amdc_spi_adc_emulator #(
  parameter int DATA_W       = ADC_DATA_W,
  parameter int TCONV_CYCLES = TCONV_DEFAULT,
  parameter int SYNC_STAGES  = SYNC_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              cnv_i,
  input  logic              sclk_i,
  input  logic [DATA_W-1:0] data_x_i,
  input  logic [DATA_W-1:0] data_y_i,
  input  logic              data_valid_i,
  input  logic              err_clr_i,
  output logic              miso_x_o,
  output logic              miso_y_o,
  output logic              sample_taken_o,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic              conv_err_o,
  output logic              frame_err_o
);

  localparam int BUSY_W = $clog2(TCONV_CYCLES + 1);
  localparam int BIT_W  = $clog2(DATA_W);

  logic cnv_lvl, cnv_lvl_vld, cnv_rise, cnv_fall;
  logic sclk_lvl, sclk_lvl_vld, sclk_rise, sclk_fall;
  logic unused_sclk;

  amdc_spi_adc_emulator_sync_edge #(.STAGES(SYNC_STAGES)) u_cnv_sync (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .async_i     (cnv_i),
    .level_o     (cnv_lvl),
    .level_vld_o (cnv_lvl_vld),
    .rise_o      (cnv_rise),
    .fall_o      (cnv_fall)
  );

  amdc_spi_adc_emulator_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .async_i     (sclk_i),
    .level_o     (sclk_lvl),
    .level_vld_o (sclk_lvl_vld),
    .rise_o      (sclk_rise),
    .fall_o      (sclk_fall)
  );

  // The responder only acts on SCLK falling edges.
  assign unused_sclk = sclk_lvl ^ sclk_lvl_vld ^ sclk_rise;

  adc_state_e        state_q, state_d;
  logic              armed_q, armed_d;
  logic [BUSY_W-1:0] busy_q, busy_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] stage_x_q, stage_x_d, stage_y_q, stage_y_d;
  logic [DATA_W-1:0] result_x_q, result_x_d, result_y_q, result_y_d;
  logic [DATA_W-1:0] shift_x_q, shift_x_d, shift_y_q, shift_y_d;
  logic              miso_x_q, miso_x_d, miso_y_q, miso_y_d;
  logic              frame_done_q, frame_done_d;
  logic              conv_err_q, conv_err_d;
  logic              frame_err_q, frame_err_d;
  logic              conv_take;
  logic              conv_err_set, frame_err_set;

  // A conversion starts only on an armed CNV rise while enabled.
  assign conv_take = cnv_rise & armed_q & en_i;

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      armed_q      <= 1'b0;
      busy_q       <= '0;
      bit_q        <= '0;
      stage_x_q    <= '0;
      stage_y_q    <= '0;
      result_x_q   <= '0;
      result_y_q   <= '0;
      shift_x_q    <= '0;
      shift_y_q    <= '0;
      miso_x_q     <= 1'b0;
      miso_y_q     <= 1'b0;
      frame_done_q <= 1'b0;
      conv_err_q   <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      armed_q      <= armed_d;
      busy_q       <= busy_d;
      bit_q        <= bit_d;
      stage_x_q    <= stage_x_d;
      stage_y_q    <= stage_y_d;
      result_x_q   <= result_x_d;
      result_y_q   <= result_y_d;
      shift_x_q    <= shift_x_d;
      shift_y_q    <= shift_y_d;
      miso_x_q     <= miso_x_d;
      miso_y_q     <= miso_y_d;
      frame_done_q <= frame_done_d;
      conv_err_q   <= conv_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Next state, datapath moves and error flags; CNV edges take priority over SCLK.
  always_comb begin
    state_d       = state_q;
    armed_d       = armed_q;
    busy_d        = (busy_q != '0) ? busy_q - 1'b1 : busy_q;
    bit_d         = bit_q;
    stage_x_d     = data_valid_i ? data_x_i : stage_x_q;
    stage_y_d     = data_valid_i ? data_y_i : stage_y_q;
    result_x_d    = result_x_q;
    result_y_d    = result_y_q;
    shift_x_d     = shift_x_q;
    shift_y_d     = shift_y_q;
    miso_x_d      = miso_x_q;
    miso_y_d      = miso_y_q;
    frame_done_d  = 1'b0;
    conv_err_set  = 1'b0;
    frame_err_set = 1'b0;

    if (!en_i) begin
      state_d  = ST_IDLE;
      armed_d  = 1'b0;
      busy_d   = busy_q;
      miso_x_d = 1'b0;
      miso_y_d = 1'b0;
    end else begin
      if (cnv_lvl_vld && !cnv_lvl) begin
        armed_d = 1'b1;
      end
      if (conv_take) begin
        state_d    = ST_CONV;
        shift_x_d  = result_x_q;
        shift_y_d  = result_y_q;
        result_x_d = data_valid_i ? data_x_i : stage_x_q;
        result_y_d = data_valid_i ? data_y_i : stage_y_q;
        busy_d     = BUSY_W'(TCONV_CYCLES);
        miso_x_d   = 1'b0;
        miso_y_d   = 1'b0;
        if (state_q == ST_READ) begin
          frame_err_set = 1'b1;
        end
      end else if (cnv_rise || cnv_fall) begin
        if (cnv_fall && state_q == ST_CONV) begin
          state_d  = ST_READ;
          miso_x_d = shift_x_q[DATA_W-1];
          miso_y_d = shift_y_q[DATA_W-1];
          bit_d    = '0;
          if (busy_q != '0) begin
            conv_err_set = 1'b1;
            busy_d       = '0;
          end
        end
      end else if (sclk_fall) begin
        case (state_q)
          ST_READ: begin
            shift_x_d = {shift_x_q[DATA_W-2:0], 1'b0};
            shift_y_d = {shift_y_q[DATA_W-2:0], 1'b0};
            if (bit_q == BIT_W'(DATA_W - 1)) begin
              state_d      = ST_DONE;
              frame_done_d = 1'b1;
              miso_x_d     = 1'b0;
              miso_y_d     = 1'b0;
            end else begin
              bit_d    = bit_q + 1'b1;
              miso_x_d = shift_x_q[DATA_W-2];
              miso_y_d = shift_y_q[DATA_W-2];
            end
          end
          ST_DONE: frame_err_set = 1'b1;
          default: ;
        endcase
      end
    end

    conv_err_d  = conv_err_set  | (conv_err_q  & ~err_clr_i);
    frame_err_d = frame_err_set | (frame_err_q & ~err_clr_i);
  end

  assign miso_x_o       = miso_x_q;
  assign miso_y_o       = miso_y_q;
  assign sample_taken_o = conv_take;
  assign busy_o         = (busy_q != '0);
  assign frame_done_o   = frame_done_q;
  assign conv_err_o     = conv_err_q;
  assign frame_err_o    = frame_err_q;

endmodule

// File: tb/tb_amdc_spi_adc_emulator.sv
// tb/tb_amdc_spi_adc_emulator.sv - scoreboard bench for the eddy-current ADC emulator
module tb_amdc_spi_adc_emulator;

  logic        clk = 1'b0;
  logic        rst, en, cnv, sclk, dv, err_clr;
  logic [17:0] dx, dy;
  logic        miso_x, miso_y, sample_taken, busy, frame_done, conv_err, frame_err;

  amdc_spi_adc_emulator dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .en_i           (en),
    .cnv_i          (cnv),
    .sclk_i         (sclk),
    .data_x_i       (dx),
    .data_y_i       (dy),
    .data_valid_i   (dv),
    .err_clr_i      (err_clr),
    .miso_x_o       (miso_x),
    .miso_y_o       (miso_y),
    .sample_taken_o (sample_taken),
    .busy_o         (busy),
    .frame_done_o   (frame_done),
    .conv_err_o     (conv_err),
    .frame_err_o    (frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: each conversion latches the most recently supplied sample;
  // a frame reads out the sample latched by the conversion before its own.
  logic [35:0] staged_m   = '0;
  logic [35:0] lastconv_m = '0;
  logic [35:0] frame_exp  = '0;
  logic [35:0] exp_q[$];
  int          exp_st = 0;
  int          exp_fd = 0;

  // Monitor state
  int          cycle = 0;
  int          rise_cycle = 0;
  int          st_cnt = 0;
  int          fd_cnt = 0;
  int          cap_n = 0;
  logic [17:0] cap_x = '0, cap_y = '0;
  logic        prev_sclk = 1'b0, prev_cnv = 1'b0;
  logic [35:0] exp_word;

  always @(negedge clk) begin
    cycle++;
    if (rst) begin
      cap_n = 0;
    end else begin
      if (cnv && !prev_cnv) begin
        rise_cycle = cycle;
        cap_n      = 0;
      end
      if (!sclk && prev_sclk) begin
        cap_x = {cap_x[16:0], miso_x};
        cap_y = {cap_y[16:0], miso_y};
        cap_n++;
      end
      if (sample_taken) begin
        st_cnt++;
        chk("sample_taken_latency", 64'(cycle - rise_cycle), 64'd3);
      end
      if (frame_done) begin
        fd_cnt++;
        chk("frame_bits", 64'(cap_n), 64'd18);
        if (exp_q.size() == 0) begin
          chk("frame_unexpected", 64'd1, 64'd0);
        end else begin
          exp_word = exp_q.pop_front();
          chk("frame_data", {28'd0, cap_x, cap_y}, {28'd0, exp_word});
        end
      end
    end
    prev_sclk = sclk;
    prev_cnv  = cnv;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic load(input logic [17:0] x, input logic [17:0] y);
    dx = x; dy = y; dv = 1'b1;
    cyc(1);
    dv = 1'b0;
    staged_m = {x, y};
  endtask

  // Raise CNV for 'high' clocks; optionally present a sample in the cycle the rise is detected.
  task automatic conv_start(input int high, input bit fwd, input logic [17:0] x, input logic [17:0] y);
    cnv = 1'b1;
    exp_st++;
    if (fwd) begin
      cyc(3);
      dx = x; dy = y; dv = 1'b1;
      staged_m = {x, y};
      cyc(1);
      dv = 1'b0;
      cyc(high - 4);
    end else begin
      cyc(high);
    end
    frame_exp  = lastconv_m;
    lastconv_m = staged_m;
  endtask

  task automatic falls(input int n);
    for (int i = 0; i < n; i++) begin
      sclk = 1'b1;
      cyc(8);
      sclk = 1'b0;
      cyc(8);
    end
  endtask

  task automatic readout(input int n);
    cyc(8);
    if (n >= 18) begin
      exp_q.push_back(frame_exp);
      exp_fd++;
    end
    falls(n);
    cyc(8);
  endtask

  task automatic frame(input int high, input int n);
    conv_start(high, 1'b0, '0, '0);
    cnv = 1'b0;
    readout(n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [17:0] rx, ry;
    int          hi;
    rst = 1'b1; en = 1'b1; cnv = 1'b1; sclk = 1'b0; dv = 1'b0; err_clr = 1'b0;
    dx = '0; dy = '0;

    // 1: reset with CNV high, then no conversion until CNV has been seen low
    cyc(5);
    chk("reset_outputs", {57'd0, miso_x, miso_y, sample_taken, busy, frame_done, conv_err, frame_err}, 64'd0);
    rst = 1'b0;
    cyc(20);
    chk("no_take_unarmed", 64'(st_cnt), 64'd0);
    chk("idle_outputs", {60'd0, miso_x, miso_y, busy, conv_err}, 64'd0);
    cnv = 1'b0;
    cyc(10);

    // 2: pipeline latency of one conversion
    load(18'h2AAAA, 18'h15555);
    conv_start(54, 1'b0, '0, '0);
    chk("busy_done_at_fall", 64'(busy), 64'd0);
    cnv = 1'b0;
    readout(18);
    chk("miso_zero_done", {62'd0, miso_x, miso_y}, 64'd0);
    frame(54, 18);
    chk("frame_count_t2", 64'(fd_cnt), 64'd2);

    // 3: sample forwarded in the detection cycle is used by that conversion
    conv_start(54, 1'b1, 18'h3FFFF, 18'h00001);
    cnv = 1'b0;
    readout(18);
    frame(54, 18);

    // 4: short CNV flags conv_err, clear works, set wins over clear
    load(18'h12345, 18'h2F0F0);
    conv_start(20, 1'b0, '0, '0);
    chk("busy_in_conv", 64'(busy), 64'd1);
    cnv = 1'b0;
    readout(18);
    chk("conv_err_set", 64'(conv_err), 64'd1);
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    cyc(1);
    chk("conv_err_clr", 64'(conv_err), 64'd0);
    conv_start(20, 1'b0, '0, '0);
    cnv = 1'b0;
    cyc(3);
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    readout(18);
    chk("conv_err_set_wins", 64'(conv_err), 64'd1);
    chk("frame_err_clean", 64'(frame_err), 64'd0);
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;

    // 5: CNV mid-read abandons the frame; extra falls in DONE flag frame_err
    load(18'h0F0F0, 18'h30303);
    frame(54, 10);
    chk("frame_err_clean2", 64'(frame_err), 64'd0);
    frame(54, 18);
    chk("frame_err_abandon", 64'(frame_err), 64'd1);
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    cyc(1);
    chk("frame_err_clr", 64'(frame_err), 64'd0);
    load(18'h2D2D2, 18'h1B1B1);
    frame(54, 20);
    chk("frame_err_overrun", 64'(frame_err), 64'd1);
    chk("miso_zero_overrun", {62'd0, miso_x, miso_y}, 64'd0);
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;

    // 6: reset mid-frame clears the pipeline
    conv_start(54, 1'b0, '0, '0);
    cnv = 1'b0;
    cyc(8);
    falls(9);
    cnv = 1'b1;
    cyc(2);
    rst = 1'b1;
    staged_m   = '0;
    lastconv_m = '0;
    cyc(3);
    rst = 1'b0;
    cyc(20);
    chk("post_reset_outputs", {57'd0, miso_x, miso_y, sample_taken, busy, frame_done, conv_err, frame_err}, 64'd0);
    chk("post_reset_no_take", 64'(st_cnt), 64'(exp_st));
    cnv = 1'b0;
    cyc(10);
    frame(54, 18);
    frame(54, 18);

    // randomized frames
    for (int i = 0; i < 6; i++) begin
      rx = 18'($urandom);
      ry = 18'($urandom);
      hi = $urandom_range(44, 70);
      if ($urandom_range(0, 2) == 0) begin
        conv_start(hi, 1'b1, rx, ry);
        cnv = 1'b0;
        readout(18);
      end else begin
        if ($urandom_range(0, 3) != 0) load(rx, ry);
        frame(hi, 18);
      end
    end
    chk("rand_no_conv_err", 64'(conv_err), 64'd0);
    chk("rand_no_frame_err", 64'(frame_err), 64'd0);

    cyc(20);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    chk("sample_taken_count", 64'(st_cnt), 64'(exp_st));
    chk("frame_done_count", 64'(fd_cnt), 64'(exp_fd));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
